alu_arbiter: RTL

Two-port arbiter that shares the team's single combinational 4-bit signed ALU between two requesters. Each requester submits an operand pair and a 4-bit opcode over a valid/ready handshake. The arbiter grants one request at a time in round-robin order and drives the registered operands onto the ALU. After a programmable settle time it captures the 6-bit result and returns it with the requester ID over a valid/ready response channel. It sits between the two operation sources and the ALU datapath; the ALU itself is instantiated outside this block.

---
 rtl/alu_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    input  logic [3:0] i_req0_a,
    input  logic [3:0] i_req0_b,
    input  logic [3:0] i_req0_sel,
    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    input  logic [3:0] i_req1_a,
    input  logic [3:0] i_req1_b,
    input  logic [3:0] i_req1_sel,
    output logic [3:0] o_alu_a,
    output logic [3:0] o_alu_b,
    output logic [3:0] o_alu_sel,
    input  logic [5:0] i_alu_y,
    output logic       o_resp_valid,
    input  logic       i_resp_ready,
    output logic [5:0] o_resp_y,
    output logic       o_resp_id,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Counter reload value: EXEC_CYCLES cycles of settle time, counted down to zero.
    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [3:0] r_alu_sel;
    logic [5:0] r_resp_y;
    logic       r_resp_id;
    logic       r_last_grant;

    logic       w_idle;
    logic       w_grant;
    logic       w_xfer;
    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [3:0] w_sel;

    // Round-robin pick: a lone requester always wins, contention goes to the one not served last.
    always_comb begin
        w_grant = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (i_req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Handshake only in IDLE and never while reset is asserted, so reset cannot race a transfer.
    always_comb begin
        w_idle       = (r_state == S_IDLE) && !i_rst;
        o_req0_ready = w_idle && i_req0_valid && !w_grant;
        o_req1_ready = w_idle && i_req1_valid && w_grant;
        w_xfer       = o_req0_ready || o_req1_ready;
        w_a          = w_grant ? i_req1_a   : i_req0_a;
        w_b          = w_grant ? i_req1_b   : i_req0_b;
        w_sel        = w_grant ? i_req1_sel : i_req0_sel;
    end

    // Next-state logic for the IDLE -> EXEC -> RESP operation cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer)        w_next_state = S_EXEC;
            S_EXEC:  if (r_cnt == 4'd0) w_next_state = S_RESP;
            S_RESP:  if (i_resp_ready)  w_next_state = S_IDLE;
            default:                    w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture on transfer, settle countdown, and result capture at the end of EXEC.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= 4'd0;
            r_alu_a      <= 4'd0;
            r_alu_b      <= 4'd0;
            r_alu_sel    <= 4'd0;
            r_resp_y     <= 6'd0;
            r_resp_id    <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_xfer) begin
                r_alu_a      <= w_a;
                r_alu_b      <= w_b;
                r_alu_sel    <= w_sel;
                r_resp_id    <= w_grant;
                r_last_grant <= w_grant;
                r_cnt        <= EXEC_LOAD;
            end else if (r_state == S_EXEC) begin
                if (r_cnt == 4'd0) begin
                    r_resp_y <= i_alu_y;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_sel    = r_alu_sel;
    assign o_resp_y     = r_resp_y;
    assign o_resp_id    = r_resp_id;
    assign o_resp_valid = (r_state == S_RESP);
    assign o_busy       = (r_state != S_IDLE);

endmodule
